// File: rtl/time_sched_pkg.sv
// Shared types and constants for the event scheduler: FSM states, default
// queue/code sizes and the timestamp width.
package time_sched_pkg;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_CW    = 8;
   localparam int TW        = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_t;
endpackage

// File: rtl/sched_fifo.sv
// Synchronous first-word-fall-through FIFO holding (timestamp, code) events.
// full/empty are registered and reflect the state after this cycle's push/pop.
module sched_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full_q, empty_q;
   logic          do_push, do_pop;

   // A push while full is dropped even when a pop frees a slot in the same cycle.
   assign do_push = push && !full_q;
   assign do_pop  = pop && !empty_q;
   assign cnt_d   = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == (AW+1)'(DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;
endmodule

// File: rtl/time_sched.sv
// Event scheduler: sequences the time-control counter (clear/divider) and fires
// queued (timestamp, code) events when the registered counter value reaches them.
module time_sched
   import time_sched_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int CW    = DEF_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic [15:0]   div_cfg,
   output logic [15:0]   nbuf,
   output logic          tc_clr,
   input  logic [TW-1:0] tc_q,
   input  logic          wr_en,
   input  logic [TW-1:0] wr_time,
   input  logic [CW-1:0] wr_code,
   output logic          full,
   output logic          empty,
   output logic          ovf,
   output logic          busy,
   output logic          ev_stb,
   output logic [CW-1:0] ev_code,
   output logic          ev_late
);
   state_t           state_q, state_d;
   logic             load;
   logic [TW-1:0]    qr_q;
   logic [15:0]      nbuf_q;
   logic             tc_clr_q, busy_q, ovf_q, ev_stb_q, ev_late_q;
   logic [CW-1:0]    ev_code_q;
   logic [TW+CW-1:0] head;
   logic [TW-1:0]    head_time;
   logic [CW-1:0]    head_code;
   logic             fire;

   sched_fifo #(.DEPTH(DEPTH), .W(TW+CW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_en),
      .pop   (fire),
      .din   ({wr_time, wr_code}),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   assign head_time = head[TW+CW-1:CW];
   assign head_code = head[CW-1:0];
   // A stop in this cycle suppresses firing so no strobe follows the stop.
   assign fire = (state_q == RUN) && !stop && !empty && (head_time <= qr_q);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: if (!stop && start) begin
            state_d = ARM;
            load    = 1'b1;
         end
         ARM:     state_d = stop ? IDLE : RUN;
         RUN:     if (stop) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         qr_q      <= '0;
         nbuf_q    <= '0;
         tc_clr_q  <= 1'b1;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
         ev_stb_q  <= 1'b0;
         ev_code_q <= '0;
         ev_late_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         qr_q     <= tc_q;
         tc_clr_q <= (state_d != RUN);
         busy_q   <= (state_d != IDLE);
         if (load) nbuf_q <= div_cfg;
         if (wr_en && full) ovf_q <= 1'b1;
         else if (load)     ovf_q <= 1'b0;
         ev_stb_q <= fire;
         if (fire) begin
            ev_code_q <= head_code;
            ev_late_q <= (head_time < qr_q);
         end
      end
   end

   assign nbuf    = nbuf_q;
   assign tc_clr  = tc_clr_q;
   assign busy    = busy_q;
   assign ovf     = ovf_q;
   assign ev_stb  = ev_stb_q;
   assign ev_code = ev_code_q;
   assign ev_late = ev_late_q;
endmodule

// File: tb/tb_time_sched.sv
// Directed bench for time_sched: reset, start/stop sequencing, firing latency,
// late events, overflow, stop/restart and asynchronous reset.
module tb_time_sched;
   import time_sched_pkg::*;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0, stop = 1'b0, wr_en = 1'b0;
   logic [15:0]   div_cfg = '0;
   logic [31:0]   tc_q = '0, wr_time = '0;
   logic [7:0]    wr_code = '0;
   logic [15:0]   nbuf;
   logic          tc_clr, full, empty, ovf, busy, ev_stb, ev_late;
   logic [7:0]    ev_code;
   int            checks = 0;
   int            failures = 0;

   time_sched #(.DEPTH(4), .CW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .div_cfg(div_cfg),
      .nbuf(nbuf), .tc_clr(tc_clr), .tc_q(tc_q), .wr_en(wr_en),
      .wr_time(wr_time), .wr_code(wr_code), .full(full), .empty(empty),
      .ovf(ovf), .busy(busy), .ev_stb(ev_stb), .ev_code(ev_code),
      .ev_late(ev_late)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tc_clr"}, 32'(tc_clr), 32'd1);
      chk({tag, "_nbuf"},   32'(nbuf),   32'd0);
      chk({tag, "_busy"},   32'(busy),   32'd0);
      chk({tag, "_ev_stb"}, 32'(ev_stb), 32'd0);
      chk({tag, "_ev_code"},32'(ev_code),32'd0);
      chk({tag, "_ev_late"},32'(ev_late),32'd0);
      chk({tag, "_ovf"},    32'(ovf),    32'd0);
      chk({tag, "_full"},   32'(full),   32'd0);
      chk({tag, "_empty"},  32'(empty),  32'd1);
   endtask

   task automatic write_ev(input logic [31:0] t, input logic [7:0] c);
      wr_en = 1'b1; wr_time = t; wr_code = c;
      tick();
      wr_en = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      check_reset_outputs("rst");
      rst = 1'b1;
      $display("txn reset released");

      // Start: ARM then RUN
      start = 1'b1; div_cfg = 16'h0010;
      tick();
      start = 1'b0;
      chk("arm_nbuf",   32'(nbuf),   32'h10);
      chk("arm_tc_clr", 32'(tc_clr), 32'd1);
      chk("arm_busy",   32'(busy),   32'd1);
      tick();
      chk("run_tc_clr", 32'(tc_clr), 32'd0);
      chk("run_busy",   32'(busy),   32'd1);
      $display("txn start div_cfg=0x0010");

      // Two events, ramping counter
      write_ev(32'd5, 8'hA1);
      write_ev(32'd9, 8'hB2);
      for (int t = 0; t <= 12; t++) begin
         tc_q = t;
         tick();
         chk("ramp_stb", 32'(ev_stb), 32'((t == 6) || (t == 10)));
         if (t == 6) begin
            chk("ramp_code_a1", 32'(ev_code), 32'hA1);
            chk("ramp_late_a1", 32'(ev_late), 32'd0);
         end
         if (t == 10) begin
            chk("ramp_code_b2", 32'(ev_code), 32'hB2);
            chk("ramp_late_b2", 32'(ev_late), 32'd0);
         end
      end
      $display("txn ramp events 0xA1@5 0xB2@9");

      // Late and exact events back to back
      tc_q = 32'd20;
      tick();
      write_ev(32'd10, 8'h01);
      chk("late_stb0", 32'(ev_stb), 32'd0);
      write_ev(32'd20, 8'h02);
      chk("late_stb1",  32'(ev_stb),  32'd1);
      chk("late_code1", 32'(ev_code), 32'h01);
      chk("late_late1", 32'(ev_late), 32'd1);
      tick();
      chk("late_stb2",  32'(ev_stb),  32'd1);
      chk("late_code2", 32'(ev_code), 32'h02);
      chk("late_late2", 32'(ev_late), 32'd0);
      tick();
      chk("late_stb3",  32'(ev_stb), 32'd0);
      chk("late_empty", 32'(empty),  32'd1);
      $display("txn late 0x01@10 exact 0x02@20");

      // Overflow with a same-cycle pop
      write_ev(32'd25,   8'hC0);
      write_ev(32'd1000, 8'hC1);
      write_ev(32'd1000, 8'hC2);
      write_ev(32'd1000, 8'hC3);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_ovf",  32'(ovf),  32'd0);
      tc_q = 32'd25;
      tick();
      write_ev(32'd2000, 8'hC4);
      chk("ovf_set",  32'(ovf),     32'd1);
      chk("ovf_full", 32'(full),    32'd0);
      chk("ovf_stb",  32'(ev_stb),  32'd1);
      chk("ovf_code", 32'(ev_code), 32'hC0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("ovf_stop_busy", 32'(busy), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ovf_clr", 32'(ovf), 32'd0);
      tick();
      tc_q = 32'd1000;
      for (int i = 0; i < 5; i++) tick();
      chk("drain_empty", 32'(empty), 32'd1);
      $display("txn overflow and drain");

      // Stop keeps queue, restart fires it
      tc_q = 32'd40;
      tick();
      write_ev(32'd50, 8'h33);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_tc_clr", 32'(tc_clr), 32'd1);
      chk("stop_busy",   32'(busy),   32'd0);
      chk("stop_stb",    32'(ev_stb), 32'd0);
      tc_q = 32'd60;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_stb", 32'(ev_stb), 32'd0);
      end
      chk("stop_kept", 32'(empty), 32'd0);
      tc_q = 32'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int t = 0; t <= 53; t++) begin
         tc_q = t;
         tick();
         chk("restart_stb", 32'(ev_stb), 32'(t == 51));
         if (t == 51) begin
            chk("restart_code", 32'(ev_code), 32'h33);
            chk("restart_late", 32'(ev_late), 32'd0);
         end
      end
      $display("txn stop/restart 0x33@50");

      // Asynchronous reset mid-RUN with a pending event
      write_ev(32'd500, 8'h44);
      tick();
      chk("arst_pending", 32'(empty), 32'd0);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("arst");
      tick();
      rst = 1'b1;
      $display("txn async reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
